// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the 2x2 max-pooling layer.
package cnn_pkg;
  localparam int BD       = 18;
  localparam int INWIDTH  = 1918;
  localparam int OUTWIDTH = INWIDTH / 2;
  localparam int NCH      = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} mp_state_t;
endpackage

// File: rtl/mp_max2.sv
// Signed two's-complement max of two W-bit samples, purely combinational.
module mp_max2 import cnn_pkg::*; #(
  parameter int W = BD
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_max
);
  assign o_max = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
endmodule

// File: rtl/maxpool_layer.sv
// 2x2 max-pool over a conv row pair streamed from two row BRAMs (1-cycle read latency).
// Define MAXPOOL_RELU_EN to clamp negative pooled channels to 0 before the output register.
module maxpool_layer import cnn_pkg::*; #(
  parameter int BD       = cnn_pkg::BD,
  parameter int INWIDTH  = cnn_pkg::INWIDTH,
  parameter int OUTWIDTH = cnn_pkg::OUTWIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            bram_sel,
  input  logic [BD*3-1:0] d_top,
  input  logic [BD*3-1:0] d_bot,
  output logic [10:0]     rdaddr,
  output logic            rd_bank,
  output logic [9:0]      wraddr,
  output logic            wren,
  output logic [BD*3-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            overrun
);
  mp_state_t r_state;
  logic      r_dcnt;
  logic      r_dv;
  logic      r_dodd;

  logic [NCH-1:0][BD-1:0] w_top, w_bot, w_rmax, w_pmax, w_pool, r_even;

  assign w_top = d_top;
  assign w_bot = d_bot;

  // Channel a sits at index NCH-1 so packing matches the MSB-first bus order.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    mp_max2 #(.W(BD)) u_row (.i_a(w_top[ch]),  .i_b(w_bot[ch]),  .o_max(w_rmax[ch]));
    mp_max2 #(.W(BD)) u_col (.i_a(w_rmax[ch]), .i_b(r_even[ch]), .o_max(w_pmax[ch]));
`ifdef MAXPOOL_RELU_EN
    assign w_pool[ch] = w_pmax[ch][BD-1] ? '0 : w_pmax[ch];
`else
    assign w_pool[ch] = w_pmax[ch];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dcnt  <= 1'b0;
      rdaddr  <= '0;
      rd_bank <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && r_state != ST_IDLE) overrun <= 1'b1;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_READ;
          rd_bank <= bram_sel;
          rdaddr  <= '0;
          busy    <= 1'b1;
        end
        ST_READ: if (rdaddr == 11'(INWIDTH - 1)) begin
          r_state <= ST_DRAIN;
          r_dcnt  <= 1'b0;
        end else begin
          rdaddr <= rdaddr + 11'd1;
        end
        ST_DRAIN: begin
          // Two cycles let the last column's data land and its write retire.
          r_dcnt <= 1'b1;
          if (r_dcnt) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dv   <= 1'b0;
      r_dodd <= 1'b0;
      r_even <= '0;
      wren   <= 1'b0;
      wdata  <= '0;
      wraddr <= '0;
    end else begin
      r_dv   <= (r_state == ST_READ);
      r_dodd <= rdaddr[0];
      wren   <= 1'b0;
      if (start && r_state == ST_IDLE) wraddr <= '0;
      else if (wren)                   wraddr <= wraddr + 10'd1;
      if (r_dv) begin
        if (!r_dodd) begin
          r_even <= w_rmax;
        end else if (wraddr < 10'(OUTWIDTH)) begin
          wdata <= w_pool;
          wren  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: BRAM model, queue-based pooling model, cycle-accurate compare.
module tb_maxpool_layer;
  localparam int BD   = 18;
  localparam int INW  = 1918;
  localparam int OUTW = 959;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, bram_sel = 1'b0;
  logic [BD*3-1:0] d_top = '0, d_bot = '0, wdata;
  logic [10:0] rdaddr;
  logic [9:0]  wraddr;
  logic rd_bank, wren, busy, done, overrun;

  maxpool_layer #(.BD(BD), .INWIDTH(INW), .OUTWIDTH(OUTW)) dut (
    .clk(clk), .reset(reset), .start(start), .bram_sel(bram_sel),
    .d_top(d_top), .d_bot(d_bot), .rdaddr(rdaddr), .rd_bank(rd_bank),
    .wraddr(wraddr), .wren(wren), .wdata(wdata), .busy(busy), .done(done),
    .overrun(overrun));

  always #5 clk = ~clk;

  logic [2:0][BD-1:0] mem_top [2][INW];
  logic [2:0][BD-1:0] mem_bot [2][INW];

  // Row BRAMs: one-cycle registered read through the bank mux.
  always @(posedge clk) begin
    if (rdaddr < 11'(INW)) begin
      d_top <= mem_top[rd_bank][rdaddr];
      d_bot <= mem_bot[rd_bank][rdaddr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [9:0] addr; logic [BD*3-1:0] data; } wr_t;
  wr_t q[$];
  int  tests = 0, fails = 0;
  bit  act = 0;
  int  n0 = 0, prev_done = -1, ovr_at = 32'h7fffffff, wr_cnt = 0;
  logic exp_bank = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  function automatic logic [BD*3-1:0] pool_exp(input int b, input int k);
    logic [2:0][BD-1:0] r;
    logic signed [BD-1:0] v[4];
    logic signed [BD-1:0] m;
    for (int ch = 0; ch < 3; ch++) begin
      v[0] = mem_top[b][2*k][ch];   v[1] = mem_bot[b][2*k][ch];
      v[2] = mem_top[b][2*k+1][ch]; v[3] = mem_bot[b][2*k+1][ch];
      m = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = '0;
`endif
      r[ch] = m;
    end
    return r;
  endfunction

  // mode 0: ramp (value = column), 1: top -5 / bot -3, 2: random, 3: channel extremes
  task automatic fill(input int b, input int mode);
    for (int i = 0; i < INW; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        case (mode)
          0: begin mem_top[b][i][ch] = BD'(i); mem_bot[b][i][ch] = BD'(i); end
          1: begin mem_top[b][i][ch] = -BD'(5); mem_bot[b][i][ch] = -BD'(3); end
          default: begin mem_top[b][i][ch] = BD'($urandom); mem_bot[b][i][ch] = BD'($urandom); end
        endcase
      end
      if (mode == 3) begin
        mem_top[b][i] = {18'h1FFFF, 18'h20000, 18'h00000};
        mem_bot[b][i] = {18'h00000, 18'h20000, 18'h3FFFF};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_start(input logic sel);
    bram_sel = sel;
    start    = 1'b1;
    if (!act || cyc >= n0 + INW + 3) begin
      prev_done = act ? n0 + INW + 3 : -1;
      act = 1; n0 = cyc; exp_bank = sel;
      for (int k = 0; k < OUTW; k++) q.push_back('{n0 + 4 + 2*k, 10'(k), pool_exp(sel, k)});
    end else if (ovr_at > cyc + 1) begin
      ovr_at = cyc + 1;
    end
    tick();
    start = 1'b0; bram_sel = 1'b0;
  endtask

  // Model comparison every cycle outside reset.
  logic ew, ed;
  always @(negedge clk) begin
    if (!reset) begin
      ew = (q.size() > 0 && q[0].c == cyc);
      ed = act && (cyc == n0 + INW + 3 || cyc == prev_done);
      chk("wren", wren, ew);
      if (ew) begin
        chk("wdata", wdata, q[0].data);
        chk("wraddr", wraddr, q[0].addr);
        void'(q.pop_front());
      end
      if (wren) wr_cnt++;
      chk("busy", busy, act && cyc >= n0 + 1 && cyc <= n0 + INW + 2);
      chk("done", done, ed);
      chk("overrun", overrun, cyc >= ovr_at);
      if (act && cyc > n0) chk("rd_bank", rd_bank, exp_bank);
      if (ed) begin
        chk("nwr", wr_cnt, OUTW);
        wr_cnt = 0;
      end
    end
  end

  initial begin
    fill(0, 2); fill(1, 2);
    repeat (3) tick();
    chk("rst_rdaddr", rdaddr, 0); chk("rst_wren", wren, 0); chk("rst_busy", busy, 0);
    chk("rst_wdata", wdata, 0);   chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Ramp on bank 1, garbage on bank 0.
    fill(1, 0); fill(0, 2);
    pulse_start(1'b1);
    wait_cyc(n0 + 3); chk("lit_nowr3", wren, 0);
    wait_cyc(n0 + 4);
    chk("lit_wren4", wren, 1); chk("lit_wa0", wraddr, 0);
    chk("lit_ramp0", wdata, {3{18'd1}}); chk("lit_bank1", rd_bank, 1);
    wait_cyc(n0 + 6); chk("lit_ramp1", wdata, {3{18'd3}});
    wait_cyc(n0 + INW + 2);
    chk("lit_wa_last", wraddr, 958); chk("lit_ramp_last", wdata, {3{18'd1917}});
    wait_cyc(n0 + INW + 3); chk("lit_done", done, 1); chk("lit_busy0", busy, 0);
    repeat (2) tick();

    // Negative constants on bank 0.
    fill(0, 1); fill(1, 2);
    pulse_start(1'b0);
    wait_cyc(n0 + 4);
`ifdef MAXPOOL_RELU_EN
    chk("lit_neg", wdata, '0);
`else
    chk("lit_neg", wdata, {3{18'h3FFFD}});
`endif
    // Back-to-back: start in the done cycle, channel extremes on bank 1.
    fill(1, 3);
    wait_cyc(n0 + INW + 3); chk("lit_done2", done, 1);
    pulse_start(1'b1);
    wait_cyc(n0 + 4);
    chk("lit_wa_restart", wraddr, 0);
`ifdef MAXPOOL_RELU_EN
    chk("lit_iso", wdata, {18'h1FFFF, 18'h00000, 18'h00000});
`else
    chk("lit_iso", wdata, {18'h1FFFF, 18'h20000, 18'h00000});
`endif
    // Overrun: a second start mid-row is ignored.
    wait_cyc(n0 + 100);
    pulse_start(1'b0);
    wait_cyc(n0 + 102); chk("lit_ovr", overrun, 1); chk("lit_bank_kept", rd_bank, 1);
    wait_cyc(n0 + INW + 5);

    // Reset mid-row.
    fill(0, 2);
    pulse_start(1'b0);
    wait_cyc(n0 + 500);
    reset = 1'b1;
    act = 0; q.delete(); prev_done = -1; ovr_at = 32'h7fffffff; exp_bank = 1'b0; wr_cnt = 0;
    #1;
    chk("ar_rdaddr", rdaddr, 0); chk("ar_wraddr", wraddr, 0); chk("ar_wdata", wdata, 0);
    chk("ar_bank", rd_bank, 0);  chk("ar_wren", wren, 0);     chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);     chk("ar_ovr", overrun, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();

    fill(1, 2);
    pulse_start(1'b1);
    wait_cyc(n0 + INW + 6);
    chk("q_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
